vga_frame_reader: RTL and testbench

//  Downstream stage of the camera capture path: scans the 160x120 (QQVGA) 3-bit frame buffer

---
 rtl/vga_frame_reader.sv | 119 +++++++++++
 tb/tb_vga_frame_reader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// Frame-buffer scan-out: 160x120 3-bit buffer upscaled 4x onto 640x480@60 VGA.
// Two-stage pipeline keeps colour, sync, DE and frame_start aligned.
module vga_frame_reader #(
  parameter int AW    = 15,
  parameter int DW    = 3,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int H_ACT = 640,
  parameter int H_FP  = 16,
  parameter int H_SYN = 96,
  parameter int H_BP  = 48,
  parameter int V_ACT = 480,
  parameter int V_FP  = 10,
  parameter int V_SYN = 2,
  parameter int V_BP  = 33
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_rd_data,
  output logic          vga_hsync,
  output logic          vga_vsync,
  output logic          vga_r,
  output logic          vga_g,
  output logic          vga_b,
  output logic          vga_de,
  output logic          frame_start
);

  localparam int H_TOT = H_ACT + H_FP + H_SYN + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYN + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] addr_q;
  logic          de1_q, hs1_q, vs1_q, fs1_q;
  logic          de_q, hs_q, vs_q, fs_q;
  logic          r_q, g_q, b_q;

  logic          h_end, v_end, act0, hs0, vs0, fs0;
  logic          base_step;
  logic [AW-1:0] addr0;

  assign h_end = h_q == HW'(H_TOT - 1);
  assign v_end = v_q == VW'(V_TOT - 1);
  assign act0  = (h_q < HW'(H_ACT)) && (v_q < VW'(V_ACT));
  assign hs0   = (h_q >= HW'(H_ACT + H_FP)) &&
                 (h_q <  HW'(H_ACT + H_FP + H_SYN));
  assign vs0   = (v_q >= VW'(V_ACT + V_FP)) &&
                 (v_q <  VW'(V_ACT + V_FP + V_SYN));
  assign fs0   = (h_q == '0) && (v_q == '0);
  assign addr0 = base_q + AW'(h_q[HW-1:2]);

  // base tracks (v>>2)*IMG_W; it stops advancing after the last stored line
  assign base_step = (v_q[1:0] == 2'd3) &&
                     (v_q[VW-1:2] < (VW-2)'(IMG_H - 1));

  always_comb begin
    h_d    = h_end ? '0 : h_q + HW'(1);
    v_d    = v_q;
    base_d = base_q;
    if (h_end) begin
      v_d = v_end ? '0 : v_q + VW'(1);
      if (v_end)
        base_d = '0;
      else if (base_step)
        base_d = base_q + AW'(IMG_W);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q    <= '0;
      v_q    <= '0;
      base_q <= '0;
      addr_q <= '0;
      de1_q  <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      fs1_q  <= 1'b0;
      de_q   <= 1'b0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      fs_q   <= 1'b0;
      r_q    <= 1'b0;
      g_q    <= 1'b0;
      b_q    <= 1'b0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      base_q <= base_d;
      addr_q <= act0 ? addr0 : '0;
      de1_q  <= act0;
      hs1_q  <= ~hs0;
      vs1_q  <= ~vs0;
      fs1_q  <= fs0;
      de_q   <= de1_q;
      hs_q   <= hs1_q;
      vs_q   <= vs1_q;
      fs_q   <= fs1_q;
      r_q    <= de1_q & mem_rd_data[2];
      g_q    <= de1_q & mem_rd_data[1];
      b_q    <= de1_q & mem_rd_data[0];
    end
  end

  assign mem_rd_addr = addr_q;
  assign vga_hsync   = hs_q;
  assign vga_vsync   = vs_q;
  assign vga_de      = de_q;
  assign frame_start = fs_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: full-size instance plus a shrunken-timing
// instance so whole frames fit in a short run.
module tb_vga_frame_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [14:0] d_addr, s_addr;
  logic [2:0]  d_data, s_data;
  logic d_hs, d_vs, d_r, d_g, d_b, d_de, d_fs;
  logic s_hs, s_vs, s_r, s_g, s_b, s_de, s_fs;
  logic ones = 1'b0;

  assign d_data = d_addr[2:0];
  assign s_data = ones ? 3'b111 : s_addr[2:0];

  vga_frame_reader u_dut (
    .clk(clk), .rst(rst),
    .mem_rd_addr(d_addr), .mem_rd_data(d_data),
    .vga_hsync(d_hs), .vga_vsync(d_vs),
    .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
    .vga_de(d_de), .frame_start(d_fs)
  );

  vga_frame_reader #(
    .IMG_W(8), .IMG_H(6),
    .H_ACT(32), .H_FP(4), .H_SYN(8), .H_BP(4),
    .V_ACT(24), .V_FP(2), .V_SYN(2), .V_BP(3)
  ) u_sm (
    .clk(clk), .rst(rst),
    .mem_rd_addr(s_addr), .mem_rd_data(s_data),
    .vga_hsync(s_hs), .vga_vsync(s_vs),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
    .vga_de(s_de), .frame_start(s_fs)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        fs;
    logic        de;
    logic        vs;
    logic        hs;
    logic [14:0] addr;
  } exp_t;

  function automatic exp_t model(int k, bit sm);
    exp_t e;
    int ha, ht, va, vt, iw, hsb, hse, vsb, vse, kk, h, v;
    ha  = sm ? 32 : 640;
    ht  = sm ? 48 : 800;
    va  = sm ? 24 : 480;
    vt  = sm ? 31 : 525;
    iw  = sm ? 8  : 160;
    hsb = ha + (sm ? 4 : 16);
    hse = hsb + (sm ? 8 : 96);
    vsb = va + (sm ? 2 : 10);
    vse = vsb + 2;
    kk  = k % (ht * vt);
    h   = kk % ht;
    v   = kk / ht;
    e.de   = (h < ha) && (v < va);
    e.hs   = !((h >= hsb) && (h < hse));
    e.vs   = !((v >= vsb) && (v < vse));
    e.fs   = (h == 0) && (v == 0);
    e.addr = e.de ? 15'((v / 4) * iw + h / 4) : 15'd0;
    return e;
  endfunction

  int s_sig_err = 0, s_adr_err = 0, s_rgb_err = 0, s_blk_err = 0;
  int d_sig_err = 0, d_adr_err = 0, d_rgb_err = 0, d_blk_err = 0;
  int s_hs_n = 0, s_vs_n = 0, s_de_n = 0, s_fs_n = 0;
  int d_hs_n = 0, d_de_n = 0, s_max = 0;

  task automatic step(int n, bit phb);
    exp_t e;
    logic [2:0] dat;
    if (n >= 1) begin
      e = model(n - 1, 1'b1);
      if (s_addr !== e.addr) s_adr_err++;
      if (int'(s_addr) > s_max) s_max = int'(s_addr);
      e = model(n - 1, 1'b0);
      if (d_addr !== e.addr) d_adr_err++;
    end
    if (n >= 2) begin
      e = model(n - 2, 1'b1);
      if ({s_fs, s_de, s_vs, s_hs} !== {e.fs, e.de, e.vs, e.hs})
        s_sig_err++;
      dat = (phb || n - 2 >= 1488) ? 3'b111 : e.addr[2:0];
      if ({s_r, s_g, s_b} !== (e.de ? dat : 3'b000)) s_rgb_err++;
      e = model(n - 2, 1'b0);
      if ({d_fs, d_de, d_vs, d_hs} !== {e.fs, e.de, e.vs, e.hs})
        d_sig_err++;
      dat = e.addr[2:0];
      if ({d_r, d_g, d_b} !== (e.de ? dat : 3'b000)) d_rgb_err++;
    end
    if (!s_de && {s_r, s_g, s_b} != 3'b000) s_blk_err++;
    if (!d_de && {d_r, d_g, d_b} != 3'b000) d_blk_err++;
    if (!phb && n >= 2 && n < 2978) begin
      if (!s_hs) s_hs_n++;
      if (!s_vs) s_vs_n++;
      if (s_de)  s_de_n++;
      if (s_fs)  s_fs_n++;
    end
    if (!phb && n >= 2 && n < 3202) begin
      if (!d_hs) d_hs_n++;
      if (d_de)  d_de_n++;
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", int'(d_addr), 0);
    chk("rst_hs", int'(d_hs), 1);
    chk("rst_vs", int'(d_vs), 1);
    chk("rst_rgb", int'({d_r, d_g, d_b}), 0);
    chk("rst_de", int'(d_de), 0);
    chk("rst_fs", int'(d_fs), 0);
    rst = 1'b0;

    for (int n = 0; n < 4100; n++) begin
      step(n, 1'b0);
      if (n == 0 || n == 1) chk("de_pre", int'(d_de), 0);
      if (n == 0) chk("fs_pre", int'(d_fs), 0);
      if (n == 2) begin
        chk("de_rise", int'(d_de), 1);
        chk("fs_rise", int'(d_fs), 1);
      end
      if (n == 1300) ones = 1'b1;
      if (n == 4010) chk("addr_162", int'(d_addr), 162);
      if (n == 4011) chk("rgb_162", int'({d_r, d_g, d_b}), 2);
      @(negedge clk);
    end

    chk("sm_hs_low", s_hs_n, 496);
    chk("sm_vs_low", s_vs_n, 192);
    chk("sm_de_high", s_de_n, 1536);
    chk("sm_fs_cnt", s_fs_n, 2);
    chk("sm_max_addr", s_max, 47);
    chk("full_hs_low", d_hs_n, 384);
    chk("full_de_high", d_de_n, 2560);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 400; n++) begin
      step(n, 1'b1);
      if (n == 0) chk("mid_de0", int'(d_de), 0);
      if (n == 1) chk("mid_addr0", int'(s_addr), 0);
      if (n == 2) begin
        chk("mid_fs_full", int'(d_fs), 1);
        chk("mid_fs_sm", int'(s_fs), 1);
      end
      if (n == 193) chk("mid_base", int'(s_addr), 8);
      @(negedge clk);
    end

    chk("sm_sig_err", s_sig_err, 0);
    chk("sm_addr_err", s_adr_err, 0);
    chk("sm_rgb_err", s_rgb_err, 0);
    chk("sm_blank_err", s_blk_err, 0);
    chk("full_sig_err", d_sig_err, 0);
    chk("full_addr_err", d_adr_err, 0);
    chk("full_rgb_err", d_rgb_err, 0);
    chk("full_blank_err", d_blk_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
